// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga decode/execute/memory interfaces.
// Only the parts used by the execute-side multiplier are defined here.
package tartaruga_pkg;

    localparam int EXE_STAGES_MULT = 4;

    typedef logic [4:0] reg_addr_t;

    typedef enum logic [1:0] {
        ALU = 2'd0,
        MUL = 2'd1,
        MEM = 2'd2,
        PC4 = 2'd3
    } wb_origin_t;

    typedef struct packed {
        logic [6:0] func7;
        reg_addr_t  rs2;
        reg_addr_t  rs1;
        logic [2:0] func3;
        reg_addr_t  rd;
        logic [6:0] opcode;
    } rtype_t;

    typedef union packed {
        logic [31:0] raw;
        rtype_t      rtype;
    } instr_u;

    typedef struct packed {
        instr_u     instr;
        wb_origin_t wb_origin;
        reg_addr_t  addr_rd;
        logic       write_enable;
    } dec_instr_t;

    typedef struct packed {
        logic        valid;
        dec_instr_t  instr;
        logic [31:0] data_rs1;
        logic [31:0] data_rs2;
    } decode_to_exe_t;

    typedef struct packed {
        logic        valid;
        dec_instr_t  instr;
        logic [31:0] data_rs2;
        logic [31:0] result;
        logic        branch_taken;
    } exe_to_mem_t;

    // addi x0, x0, 0
    localparam dec_instr_t NOP_DEC = '{
        instr: 32'h0000_0013, wb_origin: ALU, addr_rd: 5'd0, write_enable: 1'b0
    };

    localparam decode_to_exe_t NOP_INSTR = '{
        valid: 1'b0, instr: NOP_DEC, data_rs1: 32'd0, data_rs2: 32'd0
    };

endpackage

// File: rtl/exe_mul_pipe.sv
// Fixed-latency RV32M multiply pipe (MUL/MULH/MULHSU/MULHU) with stall/flush.
// Define TARTARUGA_MULH_EN to build the high-half ops; otherwise only MUL is produced.
module exe_mul_pipe
    import tartaruga_pkg::*;
#(
    parameter int STAGES = EXE_STAGES_MULT
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  decode_to_exe_t               instr_i,
    input  logic                         stall_i,
    input  logic                         flush_i,
    output exe_to_mem_t                  result_o,
    output logic                         busy_o,
    output reg_addr_t [STAGES-1:0]       pending_rd_o,
    output logic [STAGES-1:0]            pending_we_o
);

    logic        w_accept;
    logic [2:0]  w_func3;
    logic [31:0] w_result;
    exe_to_mem_t w_stg0;
    exe_to_mem_t w_rst_pkt;

    exe_to_mem_t       r_pkt [STAGES];
    logic [STAGES-1:0] r_vld;

    assign w_accept = instr_i.valid && (instr_i.instr.wb_origin == MUL) && !stall_i && !flush_i;
    assign w_func3  = instr_i.instr.instr.rtype.func3;

`ifdef TARTARUGA_MULH_EN
    logic               w_a_sgn;
    logic               w_b_sgn;
    logic signed [32:0] w_a;
    logic signed [32:0] w_b;
    logic signed [65:0] w_prod;
    logic               w_unused_hi;

    // MULH treats both operands as signed, MULHSU only rs1
    assign w_a_sgn     = (w_func3 == 3'b001) || (w_func3 == 3'b010);
    assign w_b_sgn     = (w_func3 == 3'b001);
    assign w_a         = $signed({w_a_sgn & instr_i.data_rs1[31], instr_i.data_rs1});
    assign w_b         = $signed({w_b_sgn & instr_i.data_rs2[31], instr_i.data_rs2});
    assign w_prod      = w_a * w_b;
    assign w_unused_hi = ^w_prod[65:64];

    always_comb begin
        w_result = 32'd0;
        case (w_func3)
            3'b000:                 w_result = w_prod[31:0];
            3'b001, 3'b010, 3'b011: w_result = w_prod[63:32];
            default:                w_result = 32'd0;
        endcase
    end
`else
    logic [31:0] w_lo;

    assign w_lo     = instr_i.data_rs1 * instr_i.data_rs2;
    assign w_result = (w_func3 == 3'b000) ? w_lo : 32'd0;
`endif

    always_comb begin
        w_stg0              = '0;
        w_stg0.valid        = w_accept;
        w_stg0.instr        = instr_i.instr;
        w_stg0.data_rs2     = instr_i.data_rs2;
        w_stg0.result       = w_result;
        w_stg0.branch_taken = 1'b0;

        w_rst_pkt       = '0;
        w_rst_pkt.instr = NOP_INSTR.instr;
    end

    // Data fields always shift on advance; only the valid pipe decides what is live
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld <= '0;
            for (int k = 0; k < STAGES; k++) r_pkt[k] <= w_rst_pkt;
        end else if (flush_i) begin
            r_vld <= '0;
        end else if (!stall_i) begin
            r_vld[0] <= w_accept;
            r_pkt[0] <= w_stg0;
            for (int k = 1; k < STAGES; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_pkt[k] <= r_pkt[k-1];
            end
        end
    end

    always_comb begin
        result_o       = r_pkt[STAGES-1];
        result_o.valid = r_vld[STAGES-1];
        busy_o         = |r_vld;
        for (int k = 0; k < STAGES; k++) begin
            pending_rd_o[k] = r_pkt[k].instr.addr_rd;
            pending_we_o[k] = r_vld[k] & r_pkt[k].instr.write_enable;
        end
    end

endmodule

// File: doc/exe_mul_pipe.md
# exe_mul_pipe

Multi-cycle multiply unit on the execute side of the decode→execute interface. Receives `decode_to_exe_t` packets whose `wb_origin` is `MUL` and evaluates RV32M MUL/MULH/MULHSU/MULHU in a fixed-latency, fully pipelined datapath. Emits an `exe_to_mem_t` packet `STAGES` cycles later, in parallel with the single-cycle ALU path. Supports stall and flush from the hazard/branch logic.

## Interface
Parameters:
- `STAGES`, default `tartaruga_pkg::EXE_STAGES_MULT` (4): pipeline depth = issue-to-output latency in cycles; legal range 1..8.

Ports:
- `clk_i`  in  1  clock; everything is sampled on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `instr_i`  in  `decode_to_exe_t`  issued packet from decode.
- `stall_i`  in  1  freeze all stages.
- `flush_i`  in  1  kill all in-flight entries.
- `result_o`  out  `exe_to_mem_t`  registered output of the last stage.
- `busy_o`  out  1  OR of the valid bits of all stages, including the output stage.
- `pending_rd_o`  out  `STAGES`×`reg_addr_t`  `addr_rd` per stage; index 0 is youngest. Used for the RAW hazard check.
- `pending_we_o`  out  `STAGES`  per-stage `valid & write_enable`.

## Operation
- Accept condition: `instr_i.valid && instr_i.instr.wb_origin == MUL && !stall_i && !flush_i`.
  - Packets that fail the condition do not enter; stage 0 loads valid=0.
- Operation select is `instr_i.instr.instr.rtype.func3`:
  - 000 MUL: low 32 bits of rs1×rs2.
  - 001 MULH: high 32, signed×signed.
  - 010 MULHSU: high 32, signed rs1 × unsigned rs2.
  - 011 MULHU: high 32, unsigned×unsigned.
  - 1xx: result 0; `valid` and all other fields propagate normally.
- Arithmetic:
  - Operands are extended to 33 bits (sign or zero per op) and multiplied to a 66-bit product.
  - Low slice [31:0] for MUL; [63:32] for the high ops.
  - How partial products are split across stages is an implementation choice. Only the latency and the final value are specified.
- Output packet:
  - `instr`: carried unchanged.
  - `valid`: the stage valid.
  - `data_rs2`: carried unchanged.
  - `result`: the product slice.
  - `branch_taken`: always 0.
- Stage-valid pipeline: a packet occupies exactly one stage per cycle. No reordering, no bubbles are squeezed out, throughput is 1 per cycle.
- Priority, highest first:
  1. `rst_i`
  2. `flush_i`
  3. `stall_i`
  4. normal advance.
- Flush: every stage valid, including `result_o.valid`, clears on the next edge. Data fields may keep stale values.
- Stall: every stage, including `result_o`, holds its value. Nothing is accepted; upstream must hold `instr_i`.

## Timing
- Reset values:
  - All stage valids are 0.
  - `result_o` = all-zero except `result_o.instr` = `NOP_INSTR.instr`.
  - `busy_o` = 0, `pending_we_o` = 0, `pending_rd_o` = 0.
- Latency: a packet accepted at edge N appears on `result_o` with valid=1 in the cycle after edge N+STAGES−1, i.e. `STAGES` edges after acceptance, counting the acceptance edge.
- Each stall cycle adds exactly one cycle to the latency of every in-flight packet.
- Flush and issue in the same cycle: the issued packet is also dropped.
- Reset asserted mid-operation: all in-flight packets are lost and outputs return to their reset values on that edge.
- `busy_o`, `pending_*_o` are combinational from stage registers only. They have no path from `instr_i`.

## Configuration
- `TARTARUGA_MULH_EN`
  - Defined: all four ops as above; the 33×33 signed multiplier is compiled in.
  - Undefined: only a 32×32 unsigned low-half multiplier is built. func3 000 gives the MUL result; every other func3 gives `result` = 0. Latency, valid, and control behaviour are identical.

## Test plan
- Reset → `result_o.valid`=0, `busy_o`=0, `pending_we_o`=0; then issue MUL 7×6 → `result`=0x0000002A, valid exactly 4 cycles later, `branch_taken`=0.
- Four back-to-back packets, one per cycle:
  - MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001
  - MULH 0x80000000×0x80000000 → 0x40000000
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE
  - Results appear on 4 consecutive cycles, in order. Without `TARTARUGA_MULH_EN`, the last three results are 0.
- Issue a MUL with `addr_rd`=5, `write_enable`=1, then `stall_i`=1 for 3 cycles after the 2nd edge → output delayed to 7 cycles. `pending_rd_o` shows 5 in the frozen stage and `result_o` holds during the stall.
- Two packets in flight, then `flush_i`=1 for one cycle, with a third packet issued in the same cycle → no valid output ever appears, and `busy_o`=0 after the flush edge.
- Non-MUL packet (`wb_origin`=ALU, valid=1), plus a MUL packet with `valid`=0 → neither enters; `busy_o` stays 0.
- `rst_i` pulsed while 3 packets are in flight → all lost; outputs equal their reset values on the following cycle.
